// File: rtl/i2s_codec_master_pkg.sv
// Shared constants and frame-state encoding for the I2S codec master.
package i2s_codec_master_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ADC_SLOT = 2'd1,
        DAC_SLOT = 2'd2
    } frame_state_e;

endpackage

// File: rtl/i2s_codec_master_if.sv
// Sample-side handshake plus codec pins of the I2S codec master.
interface i2s_codec_master_if;
    import i2s_codec_master_pkg::*;

    // adc_ready pulses for one clk exactly when the master consumes adc_sample at a
    // slot load; adc_valid is only looked at on that cycle. dac_valid pulses for one
    // clk when dac_sample has just been updated; there is no back-pressure.
    logic                en;
    logic [SAMPLE_W-1:0] adc_sample;
    logic                adc_valid;
    logic                adc_ready;
    logic                adc_underrun;
    logic [SAMPLE_W-1:0] dac_sample;
    logic                dac_valid;
    logic                AUD_BCLK;
    logic                AUD_ADCLRCK;
    logic                AUD_DACLRCK;
    logic                AUD_ADCDAT;
    logic                AUD_DACDAT;

    modport master (
        output en, adc_sample, adc_valid, AUD_DACDAT,
        input  adc_ready, adc_underrun, dac_sample, dac_valid,
               AUD_BCLK, AUD_ADCLRCK, AUD_DACLRCK, AUD_ADCDAT
    );

    modport slave (
        input  en, adc_sample, adc_valid, AUD_DACDAT,
        output adc_ready, adc_underrun, dac_sample, dac_valid,
               AUD_BCLK, AUD_ADCLRCK, AUD_DACLRCK, AUD_ADCDAT
    );

endinterface

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider with registered strobes marking each BCLK rising/falling toggle.
module i2s_bclk_gen #(
    parameter int BCLK_HALF = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic bclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             bclk_q, bclk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
        div_d  = div_q;
        bclk_d = bclk_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (!en_i) begin
            div_d  = '0;
            bclk_d = 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_d  = '0;
            bclk_d = ~bclk_q;
            rise_d = ~bclk_q;
            fall_d = bclk_q;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            bclk_q <= bclk_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign bclk_o = bclk_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/i2s_codec_master.sv
// I2S codec master: frame clock, ADC-slot serializer and DAC-slot deserializer.
module i2s_codec_master
    import i2s_codec_master_pkg::*;
#(
    parameter int BCLK_HALF = 2,
    parameter int SLOT_BITS = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    i2s_codec_master_if.slave  bus_if,
    output frame_state_e       state_o
);

    localparam int CNT_W = $clog2(SLOT_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_BITS - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(SAMPLE_W);

    logic bclk, bclk_rise, bclk_fall;

    i2s_bclk_gen #(.BCLK_HALF(BCLK_HALF)) u_bclk_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (bus_if.en),
        .bclk_o (bclk),
        .rise_o (bclk_rise),
        .fall_o (bclk_fall)
    );

    frame_state_e        state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                lrck_q, lrck_d;
    logic                adcdat_q, adcdat_d;
    logic [SAMPLE_W-1:0] adc_sh_q, adc_sh_d;
    logic [SAMPLE_W-1:0] dac_sh_q, dac_sh_d;
    logic [SAMPLE_W-1:0] dac_sample_q, dac_sample_d;
    logic                adc_ready_q, adc_ready_d;
    logic                dac_valid_q, dac_valid_d;
    logic                underrun_q, underrun_d;
    logic                slot_load;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        lrck_d       = lrck_q;
        adcdat_d     = adcdat_q;
        adc_sh_d     = adc_sh_q;
        dac_sh_d     = dac_sh_q;
        dac_sample_d = dac_sample_q;
        adc_ready_d  = 1'b0;
        dac_valid_d  = 1'b0;
        underrun_d   = underrun_q;
        slot_load    = 1'b0;

        if (!bus_if.en) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            lrck_d    = 1'b1;
            adcdat_d  = 1'b0;
            dac_sh_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = ADC_SLOT;
                    slot_load = 1'b1;
                end
                ADC_SLOT, DAC_SLOT: begin
                    if (bclk_fall) begin
                        if (bit_cnt_q == CNT_LAST) begin
                            bit_cnt_d = '0;
                            lrck_d    = ~lrck_q;
                            state_d   = (state_q == ADC_SLOT) ? DAC_SLOT : ADC_SLOT;
                            slot_load = (state_q == DAC_SLOT);
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                        // Bit 15 leaves at bit_cnt=1: the one-bit I2S delay after LRCK.
                        if (state_d == ADC_SLOT && bit_cnt_d != '0 && bit_cnt_d <= BIT_LAST) begin
                            adcdat_d = adc_sh_q[SAMPLE_W-1];
                            adc_sh_d = {adc_sh_q[SAMPLE_W-2:0], 1'b0};
                        end else begin
                            adcdat_d = 1'b0;
                        end
                    end
                    if (bclk_rise && state_q == DAC_SLOT && bit_cnt_q != '0 && bit_cnt_q <= BIT_LAST) begin
                        dac_sh_d = {dac_sh_q[SAMPLE_W-2:0], bus_if.AUD_DACDAT};
                        if (bit_cnt_q == BIT_LAST) begin
                            dac_sample_d = dac_sh_d;
                            dac_valid_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            if (slot_load) begin
                if (bus_if.adc_valid) begin
                    adc_sh_d    = bus_if.adc_sample;
                    adc_ready_d = 1'b1;
                end else begin
                    adc_sh_d   = '0;
                    underrun_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            lrck_q       <= 1'b1;
            adcdat_q     <= 1'b0;
            adc_sh_q     <= '0;
            dac_sh_q     <= '0;
            dac_sample_q <= '0;
            adc_ready_q  <= 1'b0;
            dac_valid_q  <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            lrck_q       <= lrck_d;
            adcdat_q     <= adcdat_d;
            adc_sh_q     <= adc_sh_d;
            dac_sh_q     <= dac_sh_d;
            dac_sample_q <= dac_sample_d;
            adc_ready_q  <= adc_ready_d;
            dac_valid_q  <= dac_valid_d;
            underrun_q   <= underrun_d;
        end
    end

    assign bus_if.AUD_BCLK     = bclk;
    assign bus_if.AUD_ADCLRCK  = lrck_q;
    assign bus_if.AUD_DACLRCK  = lrck_q;
    assign bus_if.AUD_ADCDAT   = adcdat_q;
    assign bus_if.adc_ready    = adc_ready_q;
    assign bus_if.adc_underrun = underrun_q;
    assign bus_if.dac_sample   = dac_sample_q;
    assign bus_if.dac_valid    = dac_valid_q;
    assign state_o             = state_q;

endmodule

// File: tb/tb_i2s_codec_master.sv
// Randomized bench for i2s_codec_master against a cycle-arithmetic frame model.
module tb_i2s_codec_master;
    import i2s_codec_master_pkg::*;

    localparam int H     = 2;
    localparam int S     = 32;
    localparam int FRAME = 4 * H * S;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    frame_state_e state_o;

    i2s_codec_master_if bus_if();

    i2s_codec_master #(.BCLK_HALF(H), .SLOT_BITS(S)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus_if  (bus_if),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;

    // Model state: k counts enabled clk edges since the link left idle (-1 = idle).
    int          k = -1;
    bit          ready_m = 1'b0;
    bit          dvalid_m = 1'b0;
    bit          underrun_m = 1'b0;
    logic [15:0] dac_m = '0;
    logic [15:0] dac_word = 16'h1234;
    logic [15:0] exp_adc_q[$];
    logic [15:0] exp_dac_q[$];

    function automatic int f_of(input int kk);
        return kk / (2 * H);
    endfunction
    function automatic int bc_of(input int kk);
        return f_of(kk) % S;
    endfunction
    function automatic bit lrck_of(input int kk);
        return ((f_of(kk) / S) % 2) == 0;
    endfunction
    function automatic bit bclk_of(input int kk);
        return (((kk + 1) / H) % 2) == 1;
    endfunction
    function automatic bit is_dac_cap(input int kk);
        return kk > 0 && (kk % (2 * H)) == H && !lrck_of(kk) && bc_of(kk) == 16;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s k=%0d got=%0h expected=%0h", name, k, act, exp);
        end
    endtask

    // Reference model: advances on the same edges the DUT samples its inputs.
    always @(posedge clk) begin
        ready_m  = 1'b0;
        dvalid_m = 1'b0;
        if (!rst_n) begin
            k          = -1;
            underrun_m = 1'b0;
            dac_m      = '0;
            exp_adc_q.delete();
            exp_dac_q.delete();
        end else if (!bus_if.en) begin
            k = -1;
            exp_adc_q.delete();
            exp_dac_q.delete();
        end else begin
            k++;
            if ((k % FRAME) == 0) begin
                if (bus_if.adc_valid) begin
                    exp_adc_q.push_back(bus_if.adc_sample);
                    ready_m = 1'b1;
                end else begin
                    exp_adc_q.push_back(16'h0000);
                    underrun_m = 1'b1;
                end
            end
            if (is_dac_cap(k)) begin
                dac_m    = dac_word;
                dvalid_m = 1'b1;
                exp_dac_q.push_back(dac_word);
            end
        end
    end

    // Monitor / scoreboard.
    logic [15:0]  adc_col = '0;
    logic [15:0]  w;
    bit           e_bclk, e_lrck;
    int           e_bc;
    frame_state_e e_st;

    always @(negedge clk) begin
        if (checking) begin
            if (k < 0) begin
                e_bclk = 1'b0;
                e_lrck = 1'b1;
                e_bc   = 0;
                e_st   = IDLE;
            end else begin
                e_bclk = bclk_of(k);
                e_lrck = lrck_of(k);
                e_bc   = bc_of(k);
                e_st   = e_lrck ? ADC_SLOT : DAC_SLOT;
            end
            check("bclk", 32'(bus_if.AUD_BCLK), 32'(e_bclk));
            check("adclrck", 32'(bus_if.AUD_ADCLRCK), 32'(e_lrck));
            check("daclrck", 32'(bus_if.AUD_DACLRCK), 32'(e_lrck));
            check("state", 32'(state_o), 32'(e_st));
            check("adc_ready", 32'(bus_if.adc_ready), 32'(ready_m));
            check("dac_valid", 32'(bus_if.dac_valid), 32'(dvalid_m));
            check("underrun", 32'(bus_if.adc_underrun), 32'(underrun_m));
            check("dac_sample_hold", 32'(bus_if.dac_sample), 32'(dac_m));

            if (k >= 0 && e_lrck && e_bc >= 1 && e_bc <= 16) begin
                if (exp_adc_q.size() == 0) begin
                    check("adc_exp_present", 32'(exp_adc_q.size()), 32'd1);
                end else begin
                    w = exp_adc_q[0];
                    check("adc_bit", 32'(bus_if.AUD_ADCDAT), 32'(w[16 - e_bc]));
                end
                if ((k % (2 * H)) == 0)
                    adc_col = {adc_col[14:0], bus_if.AUD_ADCDAT};
            end else begin
                check("adc_zero", 32'(bus_if.AUD_ADCDAT), 32'd0);
            end
            if (k >= 0 && e_lrck && e_bc == 17 && (k % (2 * H)) == 0 && exp_adc_q.size() > 0) begin
                w = exp_adc_q.pop_front();
                check("adc_word", 32'(adc_col), 32'(w));
            end

            if (bus_if.dac_valid) begin
                if (exp_dac_q.size() == 0) begin
                    check("dac_unexpected", 32'(bus_if.dac_valid), 32'd0);
                end else begin
                    w = exp_dac_q.pop_front();
                    check("dac_word", 32'(bus_if.dac_sample), 32'(w));
                end
            end
        end
    end

    // Player model: drives DAC bits per the model's bit position, garbage elsewhere.
    initial begin : dac_drv
        bit first_word = 1'b1;
        bit picked = 1'b0;
        int b;
        bus_if.AUD_DACDAT = 1'b0;
        forever begin
            @(negedge clk);
            if (k >= 0 && !lrck_of(k)) begin
                b = bc_of(k);
                if (b == 0 && !picked) begin
                    dac_word   = first_word ? 16'h1234 : 16'($urandom);
                    first_word = 1'b0;
                    picked     = 1'b1;
                end
                if (b != 0) picked = 1'b0;
                if (b >= 1 && b <= 16) bus_if.AUD_DACDAT = dac_word[16 - b];
                else                   bus_if.AUD_DACDAT = 1'($urandom_range(0, 1));
            end else begin
                bus_if.AUD_DACDAT = 1'($urandom_range(0, 1));
            end
        end
    end

    function automatic bit cond_met(input int which);
        case (which)
            0:       return k > 0 && (k % FRAME) == FRAME - 2;
            1:       return k >= 0 && !lrck_of(k) && bc_of(k) == 8;
            default: return k >= 0 && lrck_of(k) && bc_of(k) == 5;
        endcase
    endfunction

    task automatic wait_cond(input int which, input string name);
        bit found = 1'b0;
        for (int n = 0; n < 4 * FRAME && !found; n++) begin
            @(negedge clk);
            found = cond_met(which);
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL timeout_%s got=0 expected=1", name);
        end
    endtask

    initial begin : stim
        bus_if.en         = 1'b0;
        bus_if.adc_valid  = 1'b0;
        bus_if.adc_sample = '0;
        rst_n             = 1'b0;
        @(negedge clk);
        checking = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Held valid word, then randomized words, all frames fed in time.
        bus_if.adc_sample = 16'hA5C3;
        bus_if.adc_valid  = 1'b1;
        bus_if.en         = 1'b1;
        repeat (2 * FRAME) @(negedge clk);
        repeat (3 * FRAME) begin
            @(negedge clk);
            bus_if.adc_sample = 16'($urandom);
        end

        // Starve one slot load.
        wait_cond(0, "underrun");
        bus_if.adc_valid = 1'b0;
        repeat (4) @(negedge clk);
        bus_if.adc_valid = 1'b1;
        repeat (FRAME) @(negedge clk);
        repeat (2 * FRAME) begin
            @(negedge clk);
            bus_if.adc_sample = 16'($urandom);
            bus_if.adc_valid  = ($urandom_range(0, 9) < 7);
        end
        bus_if.adc_valid = 1'b1;

        // Drop enable mid DAC slot, then restart.
        wait_cond(1, "dac_bit8");
        bus_if.en = 1'b0;
        repeat (20) @(negedge clk);
        bus_if.en = 1'b1;
        repeat (2 * FRAME) begin
            @(negedge clk);
            bus_if.adc_sample = 16'($urandom);
        end

        // One-clk reset pulse mid ADC slot.
        wait_cond(2, "adc_bit5");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * FRAME) begin
            @(negedge clk);
            bus_if.adc_sample = 16'($urandom);
        end

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2s_codec_master.md
I2S_CODEC_MASTER -- requirements
Module: i2s_codec_master

Interface
REQ-001 Parameters: BCLK_HALF, default 2, clk cycles per BCLK half-period (min 1); SLOT_BITS, default 32, BCLK periods per LRCK half (min 18); SAMPLE_W, fixed 16, sample width.
REQ-002 clk  in  1  system clock, all logic on rising edge.
REQ-003 rst_n  in  1  synchronous active-low reset.
REQ-004 en  in  1  run enable; low = link idle.
REQ-005 adc_sample  in  16  next sample to serialize onto AUD_ADCDAT.
REQ-006 adc_valid  in  1  adc_sample holds a new sample.
REQ-007 adc_ready  out  1  one-clk pulse: adc_sample consumed.
REQ-008 adc_underrun  out  1  sticky: a slot started without adc_valid.
REQ-009 dac_sample  out  16  last sample deserialized from AUD_DACDAT.
REQ-010 dac_valid  out  1  one-clk pulse: dac_sample updated.
REQ-011 AUD_BCLK  out  1  generated bit clock.
REQ-012 AUD_ADCLRCK  out  1  ADC frame clock; 1 = ADC data slot.
REQ-013 AUD_DACLRCK  out  1  DAC frame clock, identical to AUD_ADCLRCK; 0 = DAC data slot.
REQ-014 AUD_ADCDAT  out  1  serial ADC data to the recorder.
REQ-015 AUD_DACDAT  in  1  serial DAC data from the player.

Function
REQ-016 All outputs registered; no combinational path from any input to any output.
REQ-017 BCLK: divider counts 0..BCLK_HALF-1; AUD_BCLK toggles when the count reaches its terminal value. Period = 2*BCLK_HALF clk.
REQ-018 bit_cnt, range 0..SLOT_BITS-1: increments on every BCLK falling toggle and wraps to 0. LRCK toggles on the same falling toggle as the wrap.
REQ-019 LRCK=1 slot (ADC), bit_cnt 1..16: AUD_ADCDAT = shift-register MSB, MSB first, changing only on BCLK falling toggles. Bit 15 appears at bit_cnt=1, giving a one-bit I2S delay. All other bit_cnt values: AUD_ADCDAT=0.
REQ-020 Slot load, at every LRCK 0->1 toggle and on the first enabled cycle: if adc_valid=1, load adc_sample into the shift register and pulse adc_ready. Otherwise load 16'h0000 and set adc_underrun.
REQ-021 LRCK=0 slot (DAC), bit_cnt 1..16: sample AUD_DACDAT on the BCLK rising toggle and shift it in, MSB first. After bit_cnt=16 is captured, update dac_sample and pulse dac_valid on the next clk.
REQ-022 Frame state machine: states IDLE, ADC_SLOT, DAC_SLOT.
  - IDLE -> ADC_SLOT when en=1.
  - ADC_SLOT <-> DAC_SLOT at each bit_cnt wrap.
  - Any state -> IDLE when en=0.
REQ-023 On en=0, in the same cycle: AUD_BCLK=0, LRCK=1, AUD_ADCDAT=0, divider=0, bit_cnt=0. dac_sample and adc_underrun retain their values. A partially captured DAC sample is discarded with no dac_valid.
REQ-024 adc_valid while not at a slot load is ignored; adc_ready is never asserted outside a slot load.
REQ-025 adc_underrun clears only on reset.

Reset
REQ-026 When rst_n=0 at a clk edge: AUD_BCLK=0, LRCK=1, AUD_ADCDAT=0, adc_ready=0, dac_valid=0, adc_underrun=0, dac_sample=16'h0000, shift registers=0, divider=0, bit_cnt=0, state=IDLE.
REQ-027 Reset takes priority over en. Reset mid-frame abandons the frame and emits no partial pulses.

Structure
REQ-028 A shared package holds the SAMPLE_W constant and the frame-state enum (IDLE, ADC_SLOT, DAC_SLOT).
REQ-029 One sub-module, i2s_bclk_gen: divider plus registered rise/fall toggle strobes. Slot logic lives in i2s_codec_master.

Verification
REQ-030 BCLK_HALF=2, en=1: AUD_BCLK period is 4 clk, and LRCK period is 4*2*32=256 clk.
REQ-031 adc_valid held 1 with adc_sample=16'hA5C3: AUD_ADCDAT carries 1010010111000011 at LRCK=1 bit_cnt 1..16, 0 elsewhere; one adc_ready pulse per frame.
REQ-032 Drive AUD_DACDAT with 16'h1234 MSB first in the LRCK=0 slot, bits 1..16: dac_sample=16'h1234 with one dac_valid pulse.
REQ-033 adc_valid=0 at a slot load: that slot sends all zeros and adc_underrun=1 until the next reset.
REQ-034 en dropped at bit_cnt=8 of a DAC slot: no dac_valid and outputs idle. On re-enable, the link restarts in ADC_SLOT with bit_cnt=0 and the BCLK phase as after reset.
REQ-035 rst_n pulsed low for one clk mid-ADC slot: all REQ-026 values hold on the next cycle, and adc_ready stays 0 on that cycle.
